// File: rtl/frame_collision_tracker.sv
// Frame collision tracker.
// Watches NUM_OBJ per-pixel draw requests from the sprite layers and reports
// overlap for every unordered object pair (i<j). Each enabled pair pulses at
// most once per frame. The set of pairs hit in the previous completed frame is
// latched at every frame start, and a saturating counter totals all pulses.
// Every output is registered, so there is no combinational input-to-output path.
module frame_collision_tracker #(
  parameter  int NUM_OBJ   = 4,                          // 2..8 objects
  parameter  int CNT_WIDTH = 8,                          // hit_total width
  localparam int NUM_PAIRS = NUM_OBJ * (NUM_OBJ - 1) / 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 startOfFrame,
  input  logic [NUM_OBJ-1:0]   draw_requests,
  input  logic [NUM_PAIRS-1:0] pair_enable,
  input  logic                 clr_count,
  output logic                 collision,
  output logic [NUM_PAIRS-1:0] HitPulse,
  output logic [NUM_PAIRS-1:0] frame_hits,
  output logic [CNT_WIDTH-1:0] hit_total
);

  // The sum gets four guard bits so it can never wrap before saturation.
  localparam int SUM_W = CNT_WIDTH + 4;
  localparam int POP_W = $clog2(NUM_PAIRS + 1);

  logic [NUM_PAIRS-1:0] hit_now;     // live, enabled pair overlaps this pixel
  logic [NUM_PAIRS-1:0] seen;        // pairs already pulsed in this frame
  logic [NUM_PAIRS-1:0] seen_next;
  logic [NUM_PAIRS-1:0] pulse_next;
  logic [POP_W-1:0]     pulse_cnt;
  logic [SUM_W-1:0]     sum;
  logic [CNT_WIDTH-1:0] total_next;

  // Pair k enumerates (i,j), i<j, lexicographically:
  // k = i*N - i*(i+1)/2 + (j-i-1), so (0,1)=0 ... (N-2,N-1)=NUM_PAIRS-1.
  for (genvar i = 0; i < NUM_OBJ - 1; i++) begin : g_row
    for (genvar j = i + 1; j < NUM_OBJ; j++) begin : g_col
      localparam int K = i * NUM_OBJ - i * (i + 1) / 2 + (j - i - 1);
      assign hit_now[K] = draw_requests[i] & draw_requests[j] & pair_enable[K];
    end
  end

  // Next pulse and seen flags; a frame start opens a fresh frame whose seen
  // set is exactly the hits coincident with the frame start.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    pulse_next = hit_now & ~seen;
    seen_next  = seen | hit_now;
    if (startOfFrame) begin
      pulse_next = hit_now;
      seen_next  = hit_now;
    end
  end

  // Population count of the pulses about to be registered.
  always_comb begin
    pulse_cnt = '0;
    for (int k = 0; k < NUM_PAIRS; k++) begin
      pulse_cnt = pulse_cnt + POP_W'(pulse_next[k]);
    end
  end

  // Saturating accumulate; a clear wins over pulses arriving the same cycle.
  always_comb begin
    sum = SUM_W'(hit_total) + SUM_W'(pulse_cnt);
    if (clr_count) begin
      total_next = '0;
    end else if (sum > SUM_W'({CNT_WIDTH{1'b1}})) begin
      total_next = '1;
    end else begin
      total_next = sum[CNT_WIDTH-1:0];
    end
  end

  // State and output registers; reset discards any partial frame.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      collision  <= 1'b0;
      HitPulse   <= '0;
      frame_hits <= '0;
      hit_total  <= '0;
      seen       <= '0;
    end else begin
      collision <= |hit_now;
      HitPulse  <= pulse_next;
      seen      <= seen_next;
      hit_total <= total_next;
      if (startOfFrame) begin
        frame_hits <= seen;
      end
    end
  end

endmodule
